// File: rtl/shift_count_register_pkg.sv
// Shared definitions for the shift/count register slice: mode codes for the
// multi-cycle shift engine, shift direction constants and the controller
// state encoding.
//   MODE_LOG : logical shift, vacated bit filled with 0
//   MODE_SER : serial fill from ir (right) / il (left)
//   MODE_ROT : rotate, no bits lost
//   MODE_ARI : arithmetic (MSB replicated on right, logical on left)
package shift_count_register_pkg;

    localparam logic [1:0] MODE_LOG = 2'b00;
    localparam logic [1:0] MODE_SER = 2'b01;
    localparam logic [1:0] MODE_ROT = 2'b10;
    localparam logic [1:0] MODE_ARI = 2'b11;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/shift_count_register_step.sv
// Combinational one-bit shifter shared by the single-step sr/sl operations
// and the multi-cycle shift engine.
// Ports:
//   data_i   : value to shift
//   dir_i    : DIR_RIGHT / DIR_LEFT
//   mode_i   : MODE_LOG / MODE_SER / MODE_ROT / MODE_ARI
//   fill_i   : serial fill bit, used only in MODE_SER
//   next_o   : shifted value
//   bitOut_o : the bit that falls off the end (feeds the carry flag)
module shift_step
    import shift_count_register_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             dir_i,
    input  logic [1:0]       mode_i,
    input  logic             fill_i,
    output logic [WIDTH-1:0] next_o,
    output logic             bitOut_o
);

    logic fillBit;

    // Pick the bit that enters the vacated end, then splice it onto the
    // surviving bits. Arithmetic left is deliberately identical to logical
    // left; only a right shift replicates the sign bit.
    always_comb begin
        fillBit  = 1'b0;
        next_o   = data_i;
        bitOut_o = 1'b0;
        if (dir_i == DIR_LEFT) begin
            bitOut_o = data_i[WIDTH-1];
            case (mode_i)
                MODE_SER: fillBit = fill_i;
                MODE_ROT: fillBit = data_i[WIDTH-1];
                default:  fillBit = 1'b0;
            endcase
            next_o = {data_i[WIDTH-2:0], fillBit};
        end else begin
            bitOut_o = data_i[0];
            case (mode_i)
                MODE_SER: fillBit = fill_i;
                MODE_ROT: fillBit = data_i[0];
                MODE_ARI: fillBit = data_i[WIDTH-1];
                default:  fillBit = 1'b0;
            endcase
            next_o = {fillBit, data_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/shift_count_register.sv
// General-purpose WIDTH-bit accumulator/operand register with clear, load,
// (optionally saturating) increment/decrement, single-bit shifts and a
// multi-cycle shift-by-N engine with a start/busy/done handshake.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   cl, ld, in          : clear, parallel load and its data
//   inc, dec            : count up / down by one
//   sr, ir, sl, il      : single-bit shifts and their serial fill bits
//   start, dir, mode, amt : launch a multi-cycle shift (sampled in IDLE)
//   busy, done          : engine active, one-cycle completion pulse
//   out                 : register contents
//   zero, neg           : out == 0, out MSB (combinational)
//   carry               : registered carry / borrow / last-bit-out flag
module shift_count_register
    import shift_count_register_pkg::*;
#(
    parameter int   WIDTH    = 8,
    parameter bit   SATURATE = 1'b0,
    localparam int  AMT_W    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cl,
    input  logic             ld,
    input  logic [WIDTH-1:0] in,
    input  logic             inc,
    input  logic             dec,
    input  logic             sr,
    input  logic             ir,
    input  logic             sl,
    input  logic             il,
    input  logic             start,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic [AMT_W-1:0] amt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             neg,
    output logic             carry
);

    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [AMT_W-1:0] CNT_ONE = AMT_W'(1);

    state_e           state_q;
    logic [WIDTH-1:0] out_q;
    logic             carry_q;
    logic             busy_q;
    logic             done_q;
    logic             dir_q;
    logic [1:0]       mode_q;
    logic [AMT_W-1:0] cnt_q;

    logic             stepDir_d;
    logic [1:0]       stepMode_d;
    logic             stepFill_d;
    logic [WIDTH-1:0] stepNext_d;
    logic             stepBit_d;
    logic             atMax;
    logic             atMin;

    // The single shifter is steered by the engine while shifting; in IDLE it
    // serves sr/sl as a serial-fill shift, with sr winning over sl.
    assign stepDir_d  = (state_q == ST_SHIFT) ? dir_q  : (sr ? DIR_RIGHT : DIR_LEFT);
    assign stepMode_d = (state_q == ST_SHIFT) ? mode_q : MODE_SER;
    assign stepFill_d = (stepDir_d == DIR_LEFT) ? il : ir;

    assign atMax = &out_q;
    assign atMin = ~|out_q;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .data_i   (out_q),
        .dir_i    (stepDir_d),
        .mode_i   (stepMode_d),
        .fill_i   (stepFill_d),
        .next_o   (stepNext_d),
        .bitOut_o (stepBit_d)
    );

    // Controller and datapath in one register block. IDLE takes exactly one
    // action per cycle in priority order; SHIFT ignores everything except cl
    // (abort without a done pulse). done defaults low so it is a single pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            out_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dir_q   <= 1'b0;
            mode_q  <= 2'b00;
            cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cl) begin
                        out_q   <= '0;
                        carry_q <= 1'b0;
                    end else if (ld) begin
                        out_q   <= in;
                        carry_q <= 1'b0;
                    end else if (start) begin
                        if (amt == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= ST_SHIFT;
                            busy_q  <= 1'b1;
                            dir_q   <= dir;
                            mode_q  <= mode;
                            cnt_q   <= amt;
                        end
                    end else if (inc) begin
                        if (atMax && SATURATE) begin
                            carry_q <= 1'b1;
                        end else begin
                            out_q   <= out_q + ONE;
                            carry_q <= atMax;
                        end
                    end else if (dec) begin
                        if (atMin && SATURATE) begin
                            carry_q <= 1'b1;
                        end else begin
                            out_q   <= out_q - ONE;
                            carry_q <= atMin;
                        end
                    end else if (sr || sl) begin
                        out_q   <= stepNext_d;
                        carry_q <= stepBit_d;
                    end
                end
                ST_SHIFT: begin
                    if (cl) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        out_q   <= '0;
                        carry_q <= 1'b0;
                    end else begin
                        out_q   <= stepNext_d;
                        carry_q <= stepBit_d;
                        cnt_q   <= cnt_q - CNT_ONE;
                        if (cnt_q == CNT_ONE) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign out   = out_q;
    assign carry = carry_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign zero  = ~|out_q;
    assign neg   = out_q[WIDTH-1];

endmodule

// File: tb/tb_shift_count_register.sv
// Scoreboard bench for shift_count_register (WIDTH=8). Two instances share
// all inputs: instance 0 wraps on inc/dec, instance 1 saturates. A reference
// model computes each whole operation arithmetically and queues the expected
// state; a monitor pops and compares after every clock edge.
module tb_shift_count_register;

    localparam int W     = 8;
    localparam int AMT_W = 4;

    typedef struct packed {
        logic       rstN;
        logic       cl;
        logic       ld;
        logic [7:0] din;
        logic       inc;
        logic       dec;
        logic       sr;
        logic       ir;
        logic       sl;
        logic       il;
        logic       start;
        logic       dir;
        logic [1:0] mode;
        logic [3:0] amt;
    } stim_t;

    typedef struct packed {
        logic [7:0] val;
        logic       carry;
        logic       busy;
        logic       done;
        logic       chkData;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, cl, ld, inc, dec, sr, ir, sl, il, start, dir;
    logic [7:0] din;
    logic [1:0] mode;
    logic [3:0] amt;

    logic       busyS[2], doneS[2], zeroS[2], negS[2], carryS[2];
    logic [7:0] outS[2];

    int checks = 0;
    int errors = 0;

    exp_t expQ0[$];
    exp_t expQ1[$];

    logic [7:0] mVal[2];
    logic       mCarry[2], mBusy[2], mDone[2];
    int         mRem[2];
    logic [7:0] pVal[2];
    logic       pCarry[2];
    logic       mIr, mIl;

    shift_count_register #(.WIDTH(W), .SATURATE(1'b0)) dutWrap (
        .clk(clk), .rst_n(rst_n), .cl(cl), .ld(ld), .in(din), .inc(inc), .dec(dec),
        .sr(sr), .ir(ir), .sl(sl), .il(il), .start(start), .dir(dir), .mode(mode),
        .amt(amt), .busy(busyS[0]), .done(doneS[0]), .out(outS[0]), .zero(zeroS[0]),
        .neg(negS[0]), .carry(carryS[0])
    );

    shift_count_register #(.WIDTH(W), .SATURATE(1'b1)) dutSat (
        .clk(clk), .rst_n(rst_n), .cl(cl), .ld(ld), .in(din), .inc(inc), .dec(dec),
        .sr(sr), .ir(ir), .sl(sl), .il(il), .start(start), .dir(dir), .mode(mode),
        .amt(amt), .busy(busyS[1]), .done(doneS[1]), .out(outS[1]), .zero(zeroS[1]),
        .neg(negS[1]), .carry(carryS[1])
    );

    // Final value and last-bit-out of an n-bit shift, computed in one go by
    // embedding the value in a wide word padded with the fill bit.
    function automatic void shiftResult(input logic [7:0] v, input logic d,
                                        input logic [1:0] m, input int n,
                                        input logic fillIn,
                                        output logic [7:0] r, output logic c);
        logic [15:0] dbl;
        logic [15:0] rotL;
        logic [63:0] x;
        logic [63:0] y;
        logic        f;
        int          k;
        if (m == 2'b10) begin
            dbl = {v, v};
            k   = n % W;
            if (d) begin
                rotL = dbl << k;
                r    = rotL[15:8];
                c    = v[W - 1 - ((n - 1) % W)];
            end else begin
                r = 8'(dbl >> k);
                c = v[(n - 1) % W];
            end
        end else begin
            f = (m == 2'b01) ? fillIn : ((m == 2'b11 && !d) ? v[7] : 1'b0);
            if (d) begin
                x = ({56'b0, v} << 16) | (f ? 64'hFFFF : 64'h0);
                y = x << n;
                r = y[23:16];
                c = x[24 - n];
            end else begin
                x = {{56{f}}, v};
                y = x >> n;
                r = y[7:0];
                c = x[n - 1];
            end
        end
    endfunction

    // One clock of the reference register for instance s.
    task automatic modelStep(input int s, input stim_t t);
        logic sat;
        sat      = (s == 1);
        mDone[s] = 1'b0;
        if (!t.rstN) begin
            mVal[s] = 8'h00; mCarry[s] = 1'b0; mRem[s] = 0; mBusy[s] = 1'b0;
        end else if (mRem[s] > 0) begin
            if (t.cl) begin
                mVal[s] = 8'h00; mCarry[s] = 1'b0; mRem[s] = 0; mBusy[s] = 1'b0;
            end else begin
                mRem[s] = mRem[s] - 1;
                if (mRem[s] == 0) begin
                    mVal[s] = pVal[s]; mCarry[s] = pCarry[s];
                    mDone[s] = 1'b1; mBusy[s] = 1'b0;
                end
            end
        end else if (t.cl) begin
            mVal[s] = 8'h00; mCarry[s] = 1'b0;
        end else if (t.ld) begin
            mVal[s] = t.din; mCarry[s] = 1'b0;
        end else if (t.start) begin
            if (t.amt == 4'd0) begin
                mDone[s] = 1'b1;
            end else begin
                shiftResult(mVal[s], t.dir, t.mode, int'(t.amt), t.dir ? t.il : t.ir,
                            pVal[s], pCarry[s]);
                mRem[s]  = int'(t.amt);
                mBusy[s] = 1'b1;
            end
        end else if (t.inc) begin
            mCarry[s] = (mVal[s] == 8'hFF);
            if (!(sat && mVal[s] == 8'hFF)) mVal[s] = 8'((int'(mVal[s]) + 1) % 256);
        end else if (t.dec) begin
            mCarry[s] = (mVal[s] == 8'h00);
            if (!(sat && mVal[s] == 8'h00)) mVal[s] = 8'((int'(mVal[s]) + 255) % 256);
        end else if (t.sr) begin
            mCarry[s] = mVal[s][0];
            mVal[s]   = (mVal[s] >> 1) | {t.ir, 7'b0};
        end else if (t.sl) begin
            mCarry[s] = mVal[s][7];
            mVal[s]   = (mVal[s] << 1) | {7'b0, t.il};
        end
    endtask

    // Drive one cycle of inputs, advance the model and queue its prediction.
    // Serial fill bits are held for the whole of a shift so that the model can
    // compute the result at start time.
    task automatic applyStimulus(input stim_t st);
        stim_t t;
        exp_t  e;
        t = st;
        if (mRem[0] > 0) begin
            t.ir = mIr;
            t.il = mIl;
        end else begin
            mIr = t.ir;
            mIl = t.il;
        end
        rst_n = t.rstN; cl = t.cl; ld = t.ld; din = t.din; inc = t.inc; dec = t.dec;
        sr = t.sr; ir = t.ir; sl = t.sl; il = t.il; start = t.start; dir = t.dir;
        mode = t.mode; amt = t.amt;
        for (int s = 0; s < 2; s++) begin
            modelStep(s, t);
            e.val = mVal[s]; e.carry = mCarry[s]; e.busy = mBusy[s];
            e.done = mDone[s]; e.chkData = !mBusy[s];
            if (s == 0) expQ0.push_back(e);
            else        expQ1.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input int s,
                               input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s dut%0d: got %0h expected %0h at %0t", name, s, act, req, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t t;
        t = '0;
        t.rstN = 1'b1;
        return t;
    endfunction

    task automatic doIdle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(idle());
    endtask

    task automatic doLd(input logic [7:0] v);
        stim_t t;
        t = idle(); t.ld = 1'b1; t.din = v;
        applyStimulus(t);
    endtask

    task automatic doStart(input logic d, input logic [1:0] m, input logic [3:0] a);
        stim_t t;
        t = idle(); t.start = 1'b1; t.dir = d; t.mode = m; t.amt = a;
        applyStimulus(t);
    endtask

    // Monitor: after every rising edge compare each instance with the head of
    // its expectation queue. Data and flags are only predicted while idle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            for (int s = 0; s < 2; s++) begin
                if ((s == 0 && expQ0.size() > 0) || (s == 1 && expQ1.size() > 0)) begin
                    e = (s == 0) ? expQ0.pop_front() : expQ1.pop_front();
                    checkOutput("busy", s, 32'(busyS[s]), 32'(e.busy));
                    checkOutput("done", s, 32'(doneS[s]), 32'(e.done));
                    if (e.chkData) begin
                        checkOutput("out", s, 32'(outS[s]), 32'(e.val));
                        checkOutput("carry", s, 32'(carryS[s]), 32'(e.carry));
                        checkOutput("zero", s, 32'(zeroS[s]), 32'(e.val == 8'h00));
                        checkOutput("neg", s, 32'(negS[s]), 32'(e.val[7]));
                    end
                end
            end
        end
    end

    initial begin
        stim_t t;
        for (int s = 0; s < 2; s++) begin
            mVal[s] = 8'h00; mCarry[s] = 1'b0; mBusy[s] = 1'b0; mDone[s] = 1'b0;
            mRem[s] = 0; pVal[s] = 8'h00; pCarry[s] = 1'b0;
        end
        mIr = 1'b0; mIl = 1'b0;

        t = idle(); t.rstN = 1'b0;
        applyStimulus(t);
        applyStimulus(t);
        doIdle(1);

        $display("[TB] reset in the middle of a shift");
        doLd(8'hA5);
        doStart(1'b0, 2'b00, 4'd5);
        doIdle(1);
        t = idle(); t.rstN = 1'b0;
        applyStimulus(t);
        doIdle(6);

        $display("[TB] action priority");
        doLd(8'h33);
        t = idle(); t.cl = 1'b1; t.ld = 1'b1; t.inc = 1'b1; t.din = 8'h77;
        applyStimulus(t);
        t = idle(); t.ld = 1'b1; t.inc = 1'b1; t.din = 8'h10;
        applyStimulus(t);

        $display("[TB] wrap versus saturate");
        doLd(8'hFF);
        t = idle(); t.inc = 1'b1;
        applyStimulus(t);
        doLd(8'h00);
        t = idle(); t.dec = 1'b1;
        applyStimulus(t);

        $display("[TB] rotate left");
        doLd(8'h81);
        doStart(1'b1, 2'b10, 4'd3);
        doIdle(4);

        $display("[TB] arithmetic right and zero-length shift");
        doLd(8'h90);
        doStart(1'b0, 2'b11, 4'd2);
        doIdle(3);
        doStart(1'b0, 2'b11, 4'd0);
        doIdle(2);

        $display("[TB] serial fill beyond width");
        doLd(8'h5A);
        t = idle(); t.start = 1'b1; t.dir = 1'b0; t.mode = 2'b01; t.amt = 4'd11; t.ir = 1'b1;
        applyStimulus(t);
        doIdle(13);

        $display("[TB] abort with ignored inputs");
        doLd(8'h3C);
        doStart(1'b0, 2'b00, 4'd6);
        t = idle(); t.inc = 1'b1;
        applyStimulus(t);
        t = idle(); t.ld = 1'b1; t.din = 8'hEE;
        applyStimulus(t);
        t = idle(); t.cl = 1'b1; t.start = 1'b1; t.amt = 4'd2;
        applyStimulus(t);
        doIdle(8);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 600; i++) begin
            t = idle();
            t.rstN  = ($urandom_range(0, 79) != 0);
            t.cl    = ($urandom_range(0, 23) == 0);
            t.ld    = ($urandom_range(0, 5) == 0);
            t.din   = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) ? 8'hFF : 8'h00)
                                                  : 8'($urandom);
            t.inc   = ($urandom_range(0, 3) == 0);
            t.dec   = ($urandom_range(0, 3) == 0);
            t.sr    = ($urandom_range(0, 3) == 0);
            t.sl    = ($urandom_range(0, 3) == 0);
            t.ir    = 1'($urandom);
            t.il    = 1'($urandom);
            t.start = ($urandom_range(0, 4) == 0);
            t.dir   = 1'($urandom);
            t.mode  = 2'($urandom);
            t.amt   = 4'($urandom_range(0, 15));
            applyStimulus(t);
        end
        t = idle(); t.cl = 1'b1;
        applyStimulus(t);
        doIdle(2);

        @(posedge clk);
        #2;
        checkOutput("queueDrain", 0, 32'(expQ0.size()), 32'd0);
        checkOutput("queueDrain", 1, 32'(expQ1.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
